// File: rtl/sync_arith_lockstep_checker.sv
// Lockstep divergence checker for two sync_arith_unit_12 implementations.
// Compares result/status pairs each accepted sample, counts samples and
// mismatches, and logs each mismatch (with a sample stamp) into a small FIFO
// that a downstream reader drains over a valid/ready handshake.
module sync_arith_lockstep_checker #(
    parameter int BITS         = 32,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_arm,
    input  logic                    i_disarm,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [1:0]              i_op,
    input  logic [BITS-1:0]         i_result_a,
    input  logic [3:0]              i_status_a,
    input  logic [BITS-1:0]         i_result_b,
    input  logic [3:0]              i_status_b,
    output logic [1:0]              o_state,
    output logic                    o_mismatch,
    output logic [CNT_W-1:0]        o_sample_count,
    output logic [CNT_W-1:0]        o_err_count,
    output logic                    o_overflow,
    output logic                    o_log_valid,
    input  logic                    i_log_ready,
    output logic [CNT_W+10+BITS-1:0] o_log_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] stamp;
        logic [1:0]       op;
        logic [3:0]       status_a;
        logic [3:0]       status_b;
        logic [BITS-1:0]  diff;
    } log_entry_t;

    state_t           state_q;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] stamp_q, stamp_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    log_entry_t       mem_q [DEPTH];

    logic       accept, diverge, mism, full, pop, push, drop;
    log_entry_t entry;

    // Sample qualification and FIFO handshake decode. A same-edge pop frees
    // the slot a full-FIFO mismatch needs, so that case still pushes.
    assign accept  = (state_q == ST_RUN) && i_valid && !i_clear && !i_disarm;
    assign diverge = (i_result_a != i_result_b) || (i_status_a != i_status_b);
    assign mism    = accept && diverge;
    assign full    = (count_q == DEPTH_CNT);
    assign pop     = (count_q != '0) && i_log_ready;
    assign push    = mism && (!full || pop);
    assign drop    = mism && full && !pop;

    assign entry = '{stamp:    stamp_q,
                     op:       i_op,
                     status_a: i_status_a,
                     status_b: i_status_b,
                     diff:     i_result_a ^ i_result_b};

    // Next-state for counters, stamp, overflow flag and FIFO pointers.
    always_comb begin
        mismatch_d   = mism;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        stamp_d      = stamp_q;
        overflow_d   = overflow_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (i_clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            stamp_d      = '0;
            overflow_d   = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (accept) begin
                stamp_d = stamp_q + CNT_W'(1);
                if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
                if (mism && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (drop) overflow_d = 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control FSM: clear beats disarm beats arm beats the full-drop halt.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else if (i_clear) begin
            if (state_q == ST_HALT) state_q <= ST_RUN;
        end else if (i_disarm) begin
            if (state_q != ST_IDLE) state_q <= ST_IDLE;
        end else if (i_arm && (state_q == ST_IDLE)) begin
            state_q <= ST_RUN;
        end else if (drop && (STOP_ON_FULL != 0)) begin
            state_q <= ST_HALT;
        end
    end

    // Counter, flag and pointer registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mismatch_q   <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            stamp_q      <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            mismatch_q   <= mismatch_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            stamp_q      <= stamp_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Log storage; contents need no reset since the output is gated by occupancy.
    always_ff @(posedge i_clk) begin
        if (push && !i_clear) mem_q[wr_ptr_q] <= entry;
    end

    assign o_state        = state_q;
    assign o_mismatch     = mismatch_q;
    assign o_sample_count = sample_cnt_q;
    assign o_err_count    = err_cnt_q;
    assign o_overflow     = overflow_q;
    assign o_log_valid    = (count_q != '0);
    assign o_log_data     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: doc/sync_arith_lockstep_checker.md
Name: sync_arith_lockstep_checker

Overview:
- Synthesizable receive-side companion for the sync arithmetic unit.
- Samples the o_result/o_status outputs of two sync_arith_unit_12 implementations (behavioural model and gate-level) running in lockstep on the same operands, and flags any divergence.
- Logs each mismatch into a small FIFO with a sample stamp, and keeps sample and error counters. A downstream reader drains the log over a valid/ready handshake.

Parameters:
- BITS, 32, result width of the monitored ALUs.
- DEPTH, 8, mismatch log FIFO entries (power of 2, >=2).
- CNT_W, 16, width of the sample counter, error counter and stamp.
- STOP_ON_FULL, 0: 1 = enter HALT when a mismatch finds the log full; 0 = drop the entry and set overflow.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_arm  in  1  pulse: IDLE->RUN.
- i_disarm  in  1  pulse: RUN/HALT->IDLE.
- i_clear  in  1  synchronous clear of counters, stamp, overflow flag and FIFO.
- i_valid  in  1  current cycle carries a comparable ALU output pair.
- i_op  in  2  opcode that produced this output pair (pre-aligned by the integrator).
- i_result_a  in  BITS  result, implementation A (model).
- i_status_a  in  4  status, implementation A.
- i_result_b  in  BITS  result, implementation B (gates).
- i_status_b  in  4  status, implementation B.
- o_state  out  2  00 IDLE, 01 RUN, 10 HALT.
- o_mismatch  out  1  registered one-cycle pulse per detected mismatch.
- o_sample_count  out  CNT_W  samples compared, saturating.
- o_err_count  out  CNT_W  mismatches detected, saturating.
- o_overflow  out  1  sticky: a mismatch was dropped because the log was full.
- o_log_valid  out  1  log head is valid.
- i_log_ready  in  1  reader accepts the head.
- o_log_data  out  CNT_W+10+BITS  {stamp, op, status_a, status_b, result_a^result_b}.

Behaviour:
- Reset (i_reset=0, async): state=IDLE; all counters, stamp, o_mismatch, o_overflow, o_log_valid = 0; FIFO empty; o_log_data = 0.
- A sample is accepted when state==RUN and i_valid=1 at a rising edge. Samples are ignored in IDLE and HALT.
- Mismatch = (i_result_a != i_result_b) or (i_status_a != i_status_b). Compare is full-width and exact.
- On an accepted sample:
  - stamp and sample_count increment; stamp wraps, sample_count saturates at 2^CNT_W-1.
  - The log entry uses the pre-increment stamp; the first sample after reset or clear is stamped 0.
  - If mismatch: o_mismatch=1 on the following cycle only; err_count increments (saturating); entry is pushed if the FIFO is not full.
- Mismatch with FIFO full:
  - A pop on the same edge frees a slot, so the push succeeds.
  - Otherwise the entry is dropped, o_overflow sets, and if STOP_ON_FULL=1 the state goes to HALT.
  - err_count still increments.
- FIFO:
  - Pop when o_log_valid && i_log_ready.
  - Push into an empty FIFO: o_log_valid=1 the cycle after the push edge, o_log_data = that entry.
  - o_log_data is held stable while o_log_valid=1 and i_log_ready=0.
  - Simultaneous push and pop keeps the occupancy unchanged. Pointers wrap mod DEPTH.
- FSM:
  - IDLE --i_arm--> RUN
  - RUN --i_disarm--> IDLE
  - RUN --full-drop with STOP_ON_FULL--> HALT
  - HALT --i_disarm--> IDLE
  - HALT --i_clear--> RUN
  - i_arm in RUN or HALT has no effect.
- Priority: i_clear > i_disarm > i_arm > sample processing.
  - i_clear empties the FIFO and zeroes counters, stamp and overflow.
  - A sample arriving in the same cycle as i_clear is discarded.
  - i_clear does not change IDLE or RUN; from HALT it returns to RUN.
- Sample in the same cycle as i_disarm: discarded.
- Reset mid-drain: the FIFO contents are lost and o_log_valid drops immediately (asynchronous).
- The log is still readable in IDLE and HALT; only capture is gated by state.

Test Plan:
1. Arm; 20 samples with result_a=result_b=32'h1234_5678 and status_a=status_b=4'h0 -> sample_count=20, err_count=0, o_mismatch never high, o_log_valid=0.
2. Arm; 5 matching samples, then result_a=32'hFFFF_0000, result_b=32'hFFFF_0001, i_op=2'b10, status 4'h3/4'h3 -> o_mismatch pulses 1 cycle; log entry stamp=5, op=2, xor=32'h0000_0001; err_count=1.
3. STOP_ON_FULL=0, i_log_ready=0; 10 mismatches -> 8 entries stored, o_overflow=1, err_count=10, state stays RUN. Drain -> stamps 0..7 in order.
4. STOP_ON_FULL=1 with the log full; 9th mismatch -> state=HALT, later samples ignored. i_clear -> state=RUN, counters=0, o_log_valid=0.
5. Log full; mismatch in the same cycle as a pop -> push accepted, occupancy stays 8, o_overflow stays 0.
6. Assert i_reset=0 asynchronously mid-burst with 3 entries queued -> all outputs 0 without a clock edge. Release, re-arm, one mismatch -> stamp=0.
